// File: rtl/mult_div_unit_if.sv
`default_nettype none
// =====================================================================
// mult_div_unit_if : request/result bundle of the HI/LO mult/div unit
// Revision: 1.0
// =====================================================================
interface mult_div_unit_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [5:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (output start, op, a, b, input busy, done, hi, lo);
  modport slave  (input start, op, a, b, output busy, done, hi, lo);
endinterface
`default_nettype wire

// File: rtl/mult_div_unit.sv
`default_nettype none
// =====================================================================
// mult_div_unit : iterative HI/LO multiply (shift-add) / divide
// (restoring). Option macro: MULT_DIV_SINGLE_CYCLE_MULT_EN
// Revision: 1.0
// =====================================================================
module mult_div_unit #(
  parameter int WIDTH = 32
) (
  input  wire logic      clk,
  input  wire logic      reset,
  mult_div_unit_if.slave bus
);
  localparam logic [5:0] c_op_mult  = 6'b011000;
  localparam logic [5:0] c_op_multu = 6'b011001;
  localparam logic [5:0] c_op_div   = 6'b011010;
  localparam logic [5:0] c_op_divu  = 6'b011011;
  localparam logic [5:0] c_op_mthi  = 6'b010001;
  localparam logic [5:0] c_op_mtlo  = 6'b010011;
  localparam int         c_cnt_w    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(WIDTH - 1);
  localparam logic [c_cnt_w-1:0] c_cnt_one  = c_cnt_w'(1);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, FIX = 2'd2} state_t;
  state_t r_state, w_next_state;

  logic               r_is_mul, r_neg_q, r_neg_r, r_dz, r_done;
  logic [c_cnt_w-1:0] r_cnt;
  logic [WIDTH-1:0]   r_wh, r_wl, r_opnd, r_hi, r_lo;

  logic w_mult, w_multu, w_div, w_divu, w_mthi, w_mtlo;
  logic w_signed, w_is_mul, w_is_div, w_launch;
  assign w_mult   = (bus.op == c_op_mult);
  assign w_multu  = (bus.op == c_op_multu);
  assign w_div    = (bus.op == c_op_div);
  assign w_divu   = (bus.op == c_op_divu);
  assign w_mthi   = (bus.op == c_op_mthi);
  assign w_mtlo   = (bus.op == c_op_mtlo);
  assign w_signed = w_mult | w_div;
  assign w_is_mul = w_mult | w_multu;
  assign w_is_div = w_div | w_divu;

`ifdef MULT_DIV_SINGLE_CYCLE_MULT_EN
  // Multiplies complete on the start edge, so only divides enter RUN.
  logic [2*WIDTH-1:0] w_ext_a, w_ext_b, w_fast_prod;
  assign w_ext_a     = {{WIDTH{w_signed & bus.a[WIDTH-1]}}, bus.a};
  assign w_ext_b     = {{WIDTH{w_signed & bus.b[WIDTH-1]}}, bus.b};
  assign w_fast_prod = w_ext_a * w_ext_b;
  assign w_launch    = bus.start & w_is_div;
`else
  assign w_launch    = bus.start & (w_is_mul | w_is_div);
`endif

  logic [WIDTH-1:0] w_a_mag, w_b_mag;
  assign w_a_mag = (w_signed & bus.a[WIDTH-1]) ? -bus.a : bus.a;
  assign w_b_mag = (w_signed & bus.b[WIDTH-1]) ? -bus.b : bus.b;

  // {r_wh,r_wl} is the product for multiply, {remainder,quotient} for divide.
  logic [WIDTH:0]     w_mul_sum, w_div_sh;
  logic               w_div_ge;
  logic [2*WIDTH-1:0] w_prod_mag, w_prod_fix;
  assign w_mul_sum  = {1'b0, r_wh} + (r_wl[0] ? {1'b0, r_opnd} : {(WIDTH+1){1'b0}});
  assign w_div_sh   = {r_wh, r_wl[WIDTH-1]};
  assign w_div_ge   = (w_div_sh >= {1'b0, r_opnd});
  assign w_prod_mag = {r_wh, r_wl};
  assign w_prod_fix = r_neg_q ? -w_prod_mag : w_prod_mag;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= IDLE;
    else        r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:    if (w_launch) w_next_state = RUN;
      RUN:     if (r_cnt == c_cnt_last) w_next_state = FIX;
      FIX:     w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_is_mul <= 1'b0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_dz     <= 1'b0;
      r_done   <= 1'b0;
      r_cnt    <= '0;
      r_wh     <= '0;
      r_wl     <= '0;
      r_opnd   <= '0;
      r_hi     <= '0;
      r_lo     <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: if (bus.start) begin
          if (w_mthi) r_hi <= bus.a;
          if (w_mtlo) r_lo <= bus.a;
          if (w_launch) begin
            r_wh     <= '0;
            r_wl     <= w_a_mag;
            r_opnd   <= w_b_mag;
            r_cnt    <= '0;
            r_is_mul <= w_is_mul;
            r_neg_q  <= w_signed & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
            r_neg_r  <= w_signed & bus.a[WIDTH-1];
            r_dz     <= (bus.b == '0);
          end
`ifdef MULT_DIV_SINGLE_CYCLE_MULT_EN
          if (w_is_mul) begin
            {r_hi, r_lo} <= w_fast_prod;
            r_done       <= 1'b1;
          end
`endif
        end
        RUN: begin
          r_cnt <= r_cnt + c_cnt_one;
          if (r_is_mul) begin
            r_wh <= w_mul_sum[WIDTH:1];
            r_wl <= {w_mul_sum[0], r_wl[WIDTH-1:1]};
          end else begin
            // Divisor of zero always "fits": quotient fills with ones, remainder collects the dividend.
            r_wh <= w_div_ge ? (w_div_sh[WIDTH-1:0] - r_opnd) : w_div_sh[WIDTH-1:0];
            r_wl <= {r_wl[WIDTH-2:0], w_div_ge};
          end
        end
        FIX: begin
          r_done <= 1'b1;
          if (r_is_mul) begin
            {r_hi, r_lo} <= w_prod_fix;
          end else begin
            r_lo <= r_dz ? {WIDTH{1'b1}} : (r_neg_q ? -r_wl : r_wl);
            r_hi <= r_neg_r ? -r_wh : r_wh;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.busy = (r_state != IDLE);
  assign bus.done = r_done;
  assign bus.hi   = r_hi;
  assign bus.lo   = r_lo;
endmodule
`default_nettype wire

// File: doc/mult_div_unit.md
Name: mult_div_unit

Overview:
- Iterative HI/LO multiply/divide unit in the execute stage, beside the ALU.
- Takes the same a/b operands as the ALU and the same 6-bit function-code space.
- Executes MULT, MULTU, DIV, DIVU, MTHI and MTLO, and holds the architectural HI/LO registers.
- MFHI/MFLO are served by reading the hi/lo outputs directly.

Parameters:
WIDTH, 32, operand width; HI and LO are each WIDTH bits; iteration count = WIDTH.

Ports:
clk  input  1  clock; all state changes on the rising edge.
reset  input  1  asynchronous, active-low reset (0 = reset).
start  input  1  request; sampled on a clk edge only when busy=0.
op  input  6  function code: MULT 011000, MULTU 011001, DIV 011010, DIVU 011011, MTHI 010001, MTLO 010011.
a  input  WIDTH  multiplicand / dividend / MTHI-MTLO source.
b  input  WIDTH  multiplier / divisor.
busy  output  1  operation in progress; new starts are ignored.
done  output  1  one-cycle pulse; hi/lo hold the new result in this cycle.
hi  output  WIDTH  HI register (product upper half / remainder).
lo  output  WIDTH  LO register (product lower half / quotient).

Behaviour:
- Reset:
  - reset low → immediately, regardless of clk: state IDLE, busy=0, done=0, hi=0, lo=0, counter and working registers cleared.
  - An in-flight operation is discarded; no done pulse follows.
- States: IDLE, RUN, FIX.
- IDLE, start=1 with op in {MULT, MULTU, DIV, DIVU}:
  - Latch operand magnitudes (signed ops: two's-complement absolute value; unsigned ops: raw value).
  - Latch result sign flags and the op; counter=0; go to RUN; busy=1 from the next cycle.
- IDLE, start=1 with MTHI/MTLO:
  - hi (or lo) ← a on that edge.
  - busy stays 0, done is not pulsed, the other register is unchanged.
- IDLE, start=1 with any other op: ignored.
- RUN:
  - One iteration per edge: shift-add for multiply, restoring shift-subtract for divide; counter increments.
  - After WIDTH iterations, go to FIX.
- FIX (one edge):
  - Apply sign correction and write hi/lo.
  - done=1 for the following cycle only; busy=0; return to IDLE.
- Latency: start sampled at edge 0 → hi/lo updated and done high after edge WIDTH+1 (33 for WIDTH=32). busy is high for exactly WIDTH+1 cycles.
- Sign rules:
  - MULT: negate the 2·WIDTH product if sign(a) XOR sign(b).
  - DIV: quotient negated if sign(a) XOR sign(b); remainder takes the sign of a.
  - |quotient| is truncated toward zero.
- Divide by zero (DIV/DIVU, b=0): full latency still applies; result hi=a, lo={WIDTH{1}}.
- Signed overflow: DIV 0x80000000 / 0xFFFFFFFF → lo=0x80000000, hi=0.
- start while busy=1: ignored, whatever the op, including MTHI/MTLO. Operands and op need only be valid at the sampling edge.
- hi/lo hold their values between writes. Back-to-back: a start in the done cycle is accepted (busy=0).

Optional Feature:
MULT_DIV_SINGLE_CYCLE_MULT_EN
- Defined:
  - MULT/MULTU compute the full product combinationally at the start edge and write hi/lo on that edge.
  - done pulses in the next cycle; busy never asserts.
  - DIV/DIVU are unchanged.
- Undefined: MULT/MULTU use the iterative path with WIDTH+1 latency.

Test Plan:
1. MULTU a=0xFFFFFFFF b=0xFFFFFFFF → hi=0xFFFFFFFE, lo=0x00000001; done exactly 33 cycles after the start edge (1 cycle with _EN); busy=1 for 33 cycles.
2. MULT a=0xFFFFFFFD (-3) b=7 → hi=0xFFFFFFFF, lo=0xFFFFFFEB; MULT a=0x80000000 b=0x80000000 → hi=0x40000000, lo=0.
3. DIV a=0xFFFFFFF9 (-7) b=2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF; DIVU a=7 b=2 → lo=3, hi=1; DIV a=7 b=0xFFFFFFFE → lo=0xFFFFFFFD, hi=1.
4. DIVU a=5 b=0 → hi=5, lo=0xFFFFFFFF after 33 cycles; DIV a=0x80000000 b=0xFFFFFFFF → lo=0x80000000, hi=0.
5. MTHI a=0x12345678 while idle → hi=0x12345678 next cycle, lo unchanged, no done. Then start DIVU a=9 b=4; during busy, drive start with MTLO a=0xDEADBEEF → ignored. Result: lo=2, hi=1.
6. Start DIV a=100 b=7; pull reset low asynchronously mid-cycle at cycle 10 → busy=0, done=0, hi=lo=0 before the next edge. Release reset, then MULTU a=6 b=7 → lo=42, hi=0, with no stale done pulse.
